// File: rtl/itlb_icache_pkg.sv
// Shared definitions for the instruction-fetch front end (ITLB stage plus
// direct-mapped read-only instruction cache).
//   - fault codes returned on the fetch port
//   - fill state machine encoding
//   - EMI beat width and a helper that picks one 32-bit word out of a beat
package itlb_icache_pkg;

    localparam int EMI_W = 64;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_TMISS = 2'b01;
    localparam logic [1:0] FAULT_PROT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_RELOOK = 2'd2
    } state_t;

    // Beat layout: [31:0] is the word at +0, [63:32] the word at +4.
    function automatic logic [31:0] sel_word(input logic [EMI_W-1:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/itlb_icache_dp_ram.sv
// Synchronous 1-read/1-write RAM used for the cache data and tag arrays.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset (clears the read register only)
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr       read enable/address; data appears on o_rdata after the edge
//   o_rdata            registered read data, held while i_re is low
module icache_dp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array write port (contents are not reset; validity is tracked elsewhere).
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; a write to the same address in the same cycle returns old data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/itlb_icache.sv
// Instruction-fetch front end: ITLB stage and a direct-mapped read-only
// instruction cache filled from a 64-bit external memory interface (EMI).
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   read_strobe/read_addr fetch request (word address, [1:0] ignored)
//   translation_enabled   1 = translate; no ITLB fill path, so every such fetch faults
//   privileged            reserved
//   read_data/stall/fault fetch response
//   emi_if_address/req    beat request towards memory (8-byte aligned)
//   emi_if_rdata/valid    beat response, one cycle after the request
module itlb_icache
    import itlb_icache_pkg::*;
#(
    parameter int CACHE_BYTES = 4096,
    parameter int LINE_BYTES  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_strobe,
    input  logic [31:0]      read_addr,
    input  logic             translation_enabled,
    input  logic             privileged,
    output logic [31:0]      read_data,
    output logic             stall,
    output logic [1:0]       fault,
    output logic [31:0]      emi_if_address,
    output logic             emi_if_req,
    input  logic [EMI_W-1:0] emi_if_rdata,
    input  logic             emi_if_valid
);

    localparam int LINES   = CACHE_BYTES / LINE_BYTES;
    localparam int OFF_W   = $clog2(LINE_BYTES);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = 32 - OFF_W - IDX_W;
    localparam int DADDR_W = OFF_W + IDX_W - 3;

    state_t             r_state;
    logic               r_lookup;     // an accepted request is being looked up this cycle
    logic               r_xlat;
    logic [31:0]        r_addr;
    logic               r_vbit;       // valid bit read alongside the tag
    logic               r_wait;       // beat requested last cycle, response expected now
    logic               r_emi_req;
    logic [31:0]        r_emi_addr;
    logic [31:0]        r_last_data;
    logic [LINES-1:0]   r_valid;

    logic               w_accept;
    logic               w_ren;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [DADDR_W-1:0] w_rd_daddr;
    logic [TAG_W-1:0]   w_tag_q;
    logic [EMI_W-1:0]   w_data_q;
    logic               w_hit;
    logic               w_miss;
    logic               w_result;
    logic [31:0]        w_word;
    logic               w_beat_we;
    logic               w_tag_we;
    logic [31:0]        w_next_addr;
    logic               w_last;
    logic               w_unused;

    // Arrays are read at the accepting edge with the incoming address, and
    // once more with the held address after a fill completes.
    assign w_accept   = read_strobe && !stall;
    assign w_ren      = w_accept || (r_state == ST_RELOOK);
    assign w_rd_idx   = w_accept ? read_addr[OFF_W+IDX_W-1:OFF_W] : r_addr[OFF_W+IDX_W-1:OFF_W];
    assign w_rd_daddr = w_accept ? read_addr[OFF_W+IDX_W-1:3] : r_addr[OFF_W+IDX_W-1:3];

    assign w_hit    = r_vbit && (w_tag_q == r_addr[31:OFF_W+IDX_W]);
    assign w_result = r_lookup && (r_xlat || w_hit);
    assign w_miss   = r_lookup && !r_xlat && !w_hit;
    assign w_word   = r_xlat ? 32'd0 : sel_word(w_data_q, r_addr[2]);

    assign stall     = w_miss || (r_state != ST_IDLE);
    assign read_data = w_result ? w_word : r_last_data;
    assign fault     = w_result ? (r_xlat ? FAULT_TMISS : FAULT_NONE) : FAULT_NONE;

    assign emi_if_req     = r_emi_req;
    assign emi_if_address = r_emi_addr;

    // The last beat is the one whose successor starts the next line.
    assign w_next_addr = r_emi_addr + 32'd8;
    assign w_last      = (w_next_addr[OFF_W-1:0] == '0);
    assign w_beat_we   = (r_state == ST_FILL) && r_wait && emi_if_valid;
    assign w_tag_we    = w_beat_we && w_last;

    assign w_unused = ^{privileged, r_addr[1:0]};

    icache_dp_ram #(
        .WIDTH (EMI_W),
        .DEPTH (LINES * LINE_BYTES / 8)
    ) u_data_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_beat_we),
        .i_waddr (r_emi_addr[OFF_W+IDX_W-1:3]),
        .i_wdata (emi_if_rdata),
        .i_re    (w_ren),
        .i_raddr (w_rd_daddr),
        .o_rdata (w_data_q)
    );

    icache_dp_ram #(
        .WIDTH (TAG_W),
        .DEPTH (LINES)
    ) u_tag_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_tag_we),
        .i_waddr (r_addr[OFF_W+IDX_W-1:OFF_W]),
        .i_wdata (r_addr[31:OFF_W+IDX_W]),
        .i_re    (w_ren),
        .i_raddr (w_rd_idx),
        .o_rdata (w_tag_q)
    );

    // Request capture, line-fill sequencing and valid-bit bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_lookup    <= 1'b0;
            r_xlat      <= 1'b0;
            r_addr      <= 32'd0;
            r_vbit      <= 1'b0;
            r_wait      <= 1'b0;
            r_emi_req   <= 1'b0;
            r_emi_addr  <= 32'd0;
            r_last_data <= 32'd0;
            r_valid     <= '0;
        end else begin
            if (w_result) begin
                r_last_data <= w_word;
            end else begin
                r_last_data <= r_last_data;
            end
            if (w_ren) begin
                r_vbit <= r_valid[w_rd_idx];
            end else begin
                r_vbit <= r_vbit;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lookup <= 1'b1;
                        r_addr   <= read_addr;
                        r_xlat   <= translation_enabled;
                    end else if (w_miss) begin
                        r_lookup   <= 1'b0;
                        r_state    <= ST_FILL;
                        r_emi_req  <= 1'b1;
                        r_emi_addr <= {r_addr[31:OFF_W], {OFF_W{1'b0}}};
                        r_wait     <= 1'b0;
                    end else begin
                        r_lookup <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (!r_wait) begin
                        r_emi_req <= 1'b0;
                        r_wait    <= 1'b1;
                    end else if (emi_if_valid) begin
                        r_wait <= 1'b0;
                        if (w_last) begin
                            r_valid[r_addr[OFF_W+IDX_W-1:OFF_W]] <= 1'b1;
                            r_state <= ST_RELOOK;
                        end else begin
                            r_emi_addr <= w_next_addr;
                            r_emi_req  <= 1'b1;
                        end
                    end else begin
                        // No response: ask for the same beat again.
                        r_emi_req <= 1'b1;
                        r_wait    <= 1'b0;
                    end
                end
                ST_RELOOK: begin
                    // Arrays are being re-read with the held address; that lookup now hits.
                    r_state  <= ST_IDLE;
                    r_lookup <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_lookup <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_itlb_icache.sv
// Self-checking bench for itlb_icache: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a line/tag reference model.
module tb_itlb_icache;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_strobe = 1'b0;
    logic [31:0] read_addr = 32'd0;
    logic        translation_enabled = 1'b0;
    logic        privileged = 1'b0;
    logic [31:0] read_data;
    logic        stall;
    logic [1:0]  fault;
    logic [31:0] emi_if_address;
    logic        emi_if_req;
    logic [63:0] emi_if_rdata = 64'd0;
    logic        emi_if_valid;

    int tests = 0;
    int fails = 0;

    itlb_icache dut (
        .clk                 (clk),
        .reset               (reset),
        .read_strobe         (read_strobe),
        .read_addr           (read_addr),
        .translation_enabled (translation_enabled),
        .privileged          (privileged),
        .read_data           (read_data),
        .stall               (stall),
        .fault               (fault),
        .emi_if_address      (emi_if_address),
        .emi_if_req          (emi_if_req),
        .emi_if_rdata        (emi_if_rdata),
        .emi_if_valid        (emi_if_valid)
    );

    always #5 clk = ~clk;

    // Memory content: word k of memory holds mword(k).
    function automatic logic [31:0] mword(input logic [31:0] k);
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ k;
    endfunction

    logic [63:0] mem [1024];
    logic [31:0] emi_log [4096];
    int          emi_cnt = 0;

    assign emi_if_valid = 1'b1;

    always @(posedge clk) begin
        if (emi_if_req) begin
            emi_if_rdata <= mem[emi_if_address[12:3]];
            emi_log[emi_cnt % 4096] <= emi_if_address;
            emi_cnt <= emi_cnt + 1;
        end
    end

    // Reference cache state: which tag each line holds.
    logic        ref_valid [128];
    logic [31:0] ref_tag   [128];

    typedef struct {
        logic [31:0] addr;
        logic        xlat;
        logic        exp_miss;
        logic [1:0]  exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return mword((a & 32'h0000_1FFF) >> 2);
    endfunction

    // Issue one fetch at posedge+1 and wait for its result; returns at posedge+1 of the result cycle.
    task automatic do_read(input logic [31:0] a, input logic x, input logic keep,
                           output logic [31:0] d, output logic [1:0] f, output logic miss,
                           output int cyc, output int nreq, output int base);
        base = emi_cnt;
        read_strobe = 1'b1;
        read_addr = a;
        translation_enabled = x;
        @(posedge clk);
        #1;
        cyc = 1;
        miss = stall;
        while (stall && cyc < 1023) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (stall) check("timeout", 64'(cyc), 64'd0);
        d = read_data;
        f = fault;
        nreq = emi_cnt - base;
        if (!keep) read_strobe = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [31:0] a, input logic x, input logic keep,
                              input logic exp_miss, input logic [1:0] exp_f, input logic [31:0] exp_d);
        logic [31:0] d;
        logic [1:0]  f;
        logic        miss;
        int          cyc, nreq, base;
        do_read(a, x, keep, d, f, miss, cyc, nreq, base);
        check({name, ".data"}, 64'(d), 64'(exp_d));
        check({name, ".fault"}, 64'(f), 64'(exp_f));
        check({name, ".miss"}, 64'(miss), 64'(exp_miss));
        check({name, ".emi_reqs"}, 64'(nreq), exp_miss ? 64'd4 : 64'd0);
        if (exp_miss) begin
            check({name, ".latency_bound"}, 64'(cyc <= 12), 64'd1);
            for (int j = 0; j < 4 && j < nreq; j++) begin
                check({name, ".beat_addr"}, 64'(emi_log[(base + j) % 4096]),
                      64'((a & 32'hFFFF_FFE0) + 32'(8 * j)));
            end
        end else begin
            check({name, ".latency"}, 64'(cyc), 64'd1);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
    endtask

    // Predicts hit/miss from line index and tag, then records the refill.
    task automatic ref_read(input string name, input logic [31:0] a, input logic x, input logic keep);
        int          line;
        logic [31:0] tag;
        logic        m;
        line = int'((a / 32'd32) % 32'd128);
        tag  = a / 32'd4096;
        if (x) begin
            check_read(name, a, 1'b1, keep, 1'b0, 2'b01, 32'd0);
        end else begin
            m = !(ref_valid[line] && ref_tag[line] == tag);
            check_read(name, a, 1'b0, keep, m, 2'b00, exp_word(a));
            ref_valid[line] = 1'b1;
            ref_tag[line] = tag;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] held;
        logic [31:0] d;
        logic [1:0]  f;
        logic        miss;
        int          cyc, nreq, base;

        for (int i = 0; i < 1024; i++) mem[i] = {mword(32'(2 * i + 1)), mword(32'(2 * i))};
        ref_clear();

        vecs[0] = '{32'h0000_0030, 1'b0, 1'b1, 2'b00, mword(32'h0C)};
        vecs[1] = '{32'h0000_0068, 1'b0, 1'b1, 2'b00, mword(32'h1A)};
        vecs[2] = '{32'h0000_0184, 1'b0, 1'b1, 2'b00, mword(32'h61)};
        vecs[3] = '{32'h0000_0180, 1'b0, 1'b0, 2'b00, mword(32'h60)};
        vecs[4] = '{32'h0000_1030, 1'b0, 1'b1, 2'b00, mword(32'h40C)};
        vecs[5] = '{32'h0000_0030, 1'b0, 1'b1, 2'b00, mword(32'h0C)};
        vecs[6] = '{32'h0000_0030, 1'b1, 1'b0, 2'b01, 32'd0};
        vecs[7] = '{32'h0000_0037, 1'b0, 1'b0, 2'b00, mword(32'h0D)};

        // Reset values.
        #13;
        check("rst.stall", 64'(stall), 64'd0);
        check("rst.fault", 64'(fault), 64'd0);
        check("rst.emi_req", 64'(emi_if_req), 64'd0);
        check("rst.emi_addr", 64'(emi_if_address), 64'd0);
        check("rst.read_data", 64'(read_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table: cold misses, hit, conflict refill, translation fault.
        for (int i = 0; i < 8; i++) begin
            check_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].xlat, 1'b0,
                       vecs[i].exp_miss, vecs[i].exp_fault, vecs[i].exp_data);
        end

        // Outputs hold while no request is presented.
        held = mword(32'h0D);
        repeat (3) @(posedge clk);
        #1;
        check("hold.read_data", 64'(read_data), 64'(held));
        check("hold.stall", 64'(stall), 64'd0);

        // Strobe held, address changed at each return cycle: two hits then a miss.
        check_read("b2b0", 32'h0000_0030, 1'b0, 1'b1, 1'b0, 2'b00, mword(32'h0C));
        check_read("b2b1", 32'h0000_0068, 1'b0, 1'b1, 1'b0, 2'b00, mword(32'h1A));
        check_read("b2b2", 32'h0000_0110, 1'b0, 1'b0, 1'b1, 2'b00, mword(32'h44));

        // Reset in the middle of a fill, then the same address refills completely.
        read_strobe = 1'b1;
        read_addr = 32'h0000_0200;
        translation_enabled = 1'b0;
        @(posedge clk);
        #1;
        read_strobe = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst.stall", 64'(stall), 64'd0);
        check("midrst.emi_req", 64'(emi_if_req), 64'd0);
        check("midrst.read_data", 64'(read_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        ref_clear();
        ref_read("midrst.refill", 32'h0000_0200, 1'b0, 1'b0);
        ref_read("midrst.cold30", 32'h0000_0030, 1'b0, 1'b0);
        ref_read("midrst.rehit", 32'h0000_0204, 1'b0, 1'b0);

        // Randomized traffic over a small set of lines/tags so hits and conflicts both occur.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] tagsel;
            int gap;
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                read_strobe = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 3))
                0: tagsel = 32'd0;
                1: tagsel = 32'd1;
                2: tagsel = 32'd2;
                default: tagsel = 32'h000F_FFFF;
            endcase
            a = (tagsel << 12) + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 7) * 4)
                + 32'($urandom_range(0, 3));
            ref_read($sformatf("rnd%0d", n), a, ($urandom_range(0, 7) == 0), 1'b0);
        end

        // Translation fault leaves the cache untouched: a previously filled line still hits.
        do_read(32'h0000_0204, 1'b1, 1'b0, d, f, miss, cyc, nreq, base);
        check("xlat.fault", 64'(f), 64'd1);
        check("xlat.emi_reqs", 64'(nreq), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
